// File: rtl/ysyx_22041071_axi_r_pkg.sv
// Shared AXI read-master widths, protocol encodings and FSM state type.
// Latency: none (definitions only).
// Backpressure: n/a.
package ysyx_22041071_axi_r_pkg;

  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 64;
  localparam int AXI_ID_W   = 4;
  localparam int AXI_LEN_W  = 8;
  localparam int AXI_RESP_W = 2;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [2:0] AXI_SIZE_8B     = 3'b011;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_DATA = 2'd2,
    R_DONE = 2'd3
  } r_state_e;

  // Sticky worst-case response: numerically larger AXI codes are worse.
  function automatic logic [AXI_RESP_W-1:0] resp_worst(input logic [AXI_RESP_W-1:0] a,
                                                       input logic [AXI_RESP_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ysyx_22041071_rdata_align.sv
// Right-justifies a read beat by the byte offset and zero-masks it to the access size.
// Latency: combinational.
// Backpressure: none.
module ysyx_22041071_rdata_align #(
  parameter int DATA_W = 64
) (
  input  logic [DATA_W-1:0] data_i,
  input  logic [2:0]        offset_i,
  input  logic [1:0]        size_i,
  output logic [DATA_W-1:0] data_o
);

  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] mask;

  // Shift the addressed byte down to bit 0, then keep only 1/2/4/8 bytes.
  always_comb begin
    shifted = data_i >> {offset_i, 3'b000};
    mask    = '0;
    case (size_i)
      2'b00:   mask[7:0]  = '1;
      2'b01:   mask[15:0] = '1;
      2'b10:   mask[31:0] = '1;
      default: mask       = '1;
    endcase
    data_o = shifted & mask;
  end

endmodule

// File: rtl/ysyx_22041071_axi_r.sv
// AXI4 read master: one CPU request -> AR -> INCR burst on R -> per-beat pulses + aligned result.
// Latency: accept T0 -> ARVALID T1; R handshake Tk -> beat pulse Tk+1; last -> done Tn+1, ready Tn+2.
// Backpressure: cpu_ar_ready only in idle; RREADY held high throughout the data phase.
// Optional: define YSYX_22041071_AXI_R_ID_CHECK_EN to flag RID mismatches as SLVERR.
module ysyx_22041071_axi_r
  import ysyx_22041071_axi_r_pkg::*;
#(
  parameter int ADDR_W = AXI_ADDR_W,
  parameter int DATA_W = AXI_DATA_W,
  parameter int ID_W   = AXI_ID_W,
  parameter int LEN_W  = AXI_LEN_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_ar_valid,
  output logic              cpu_ar_ready,
  input  logic [ID_W-1:0]   cpu_id,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [LEN_W-1:0]  cpu_ar_len,
  input  logic [1:0]        cpu_size,
  output logic              cpu_r_beat_valid,
  output logic [DATA_W-1:0] cpu_r_beat_data,
  output logic [LEN_W-1:0]  cpu_r_beat_idx,
  output logic              cpu_r_done,
  output logic [DATA_W-1:0] cpu_r_data,
  output logic [1:0]        cpu_r_resp,
  output logic              axi_ar_valid_o,
  input  logic              axi_ar_ready_i,
  output logic [ID_W-1:0]   axi_ar_id_o,
  output logic [ADDR_W-1:0] axi_ar_addr_o,
  output logic [LEN_W-1:0]  axi_ar_len_o,
  output logic [2:0]        axi_ar_size_o,
  output logic [1:0]        axi_ar_burst_o,
  output logic [2:0]        axi_ar_prot_o,
  output logic [3:0]        axi_ar_cache_o,
  output logic [3:0]        axi_ar_qos_o,
  output logic [3:0]        axi_ar_region_o,
  output logic              axi_ar_lock_o,
  output logic              axi_ar_user_o,
  input  logic              axi_r_valid_i,
  output logic              axi_r_ready_o,
  input  logic [ID_W-1:0]   axi_r_id_i,
  input  logic [DATA_W-1:0] axi_r_data_i,
  input  logic [1:0]        axi_r_resp_i,
  input  logic              axi_r_last_i,
  input  logic              axi_r_user_i
);

  r_state_e          state_q;
  logic [ID_W-1:0]   id_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  len_q;
  logic [1:0]        size_q;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        resp_q, resp_d;
  logic              beat_vld_q;
  logic [DATA_W-1:0] beat_dat_q;
  logic [LEN_W-1:0]  beat_idx_q;
  logic              done_q;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] aligned;
  logic              r_hs;
  logic              cnt_at_len;
  logic              len_err;
  logic              id_err;

`ifdef YSYX_22041071_AXI_R_ID_CHECK_EN
  logic unused_r_sideband;
  assign id_err            = (axi_r_id_i != id_q);
  assign unused_r_sideband = axi_r_user_i;
`else
  logic unused_r_sideband;
  assign id_err            = 1'b0;
  assign unused_r_sideband = ^{axi_r_id_i, axi_r_user_i};
`endif

  // Handshake/valid signals come straight from the state register.
  assign cpu_ar_ready   = (state_q == R_IDLE);
  assign axi_ar_valid_o = (state_q == R_ADDR);
  assign axi_r_ready_o  = (state_q == R_DATA);

  assign axi_ar_id_o     = id_q;
  assign axi_ar_addr_o   = {addr_q[ADDR_W-1:3], 3'b000};
  assign axi_ar_len_o    = len_q;
  assign axi_ar_size_o   = AXI_SIZE_8B;
  assign axi_ar_burst_o  = AXI_BURST_INCR;
  assign axi_ar_prot_o   = '0;
  assign axi_ar_cache_o  = '0;
  assign axi_ar_qos_o    = '0;
  assign axi_ar_region_o = '0;
  assign axi_ar_lock_o   = 1'b0;
  assign axi_ar_user_o   = 1'b0;

  assign cpu_r_beat_valid = beat_vld_q;
  assign cpu_r_beat_data  = beat_dat_q;
  assign cpu_r_beat_idx   = beat_idx_q;
  assign cpu_r_done       = done_q;
  assign cpu_r_data       = rdata_q;
  assign cpu_r_resp       = resp_q;

  ysyx_22041071_rdata_align #(
    .DATA_W(DATA_W)
  ) u_align (
    .data_i  (axi_r_data_i),
    .offset_i(addr_q[2:0]),
    .size_i  (size_q),
    .data_o  (aligned)
  );

  // Per-beat bookkeeping: saturating beat count and sticky worst-case response,
  // with burst-length disagreement (early or missing RLAST) reported as SLVERR.
  always_comb begin
    r_hs       = axi_r_ready_o && axi_r_valid_i;
    cnt_at_len = (cnt_q == len_q);
    cnt_d      = cnt_at_len ? cnt_q : cnt_q + 1'b1;
    len_err    = axi_r_last_i ? !cnt_at_len : cnt_at_len;
    resp_d     = resp_worst(resp_q, axi_r_resp_i);
    if (len_err || id_err) begin
      resp_d = AXI_RESP_SLVERR;
    end
  end

  // FSM with request latch, beat counter, response accumulation and CPU pulses.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= R_IDLE;
      id_q       <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      size_q     <= '0;
      cnt_q      <= '0;
      resp_q     <= AXI_RESP_OKAY;
      beat_vld_q <= 1'b0;
      beat_dat_q <= '0;
      beat_idx_q <= '0;
      done_q     <= 1'b0;
      rdata_q    <= '0;
    end else begin
      beat_vld_q <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        R_IDLE: begin
          cnt_q <= '0;
          if (cpu_ar_valid) begin
            id_q    <= cpu_id;
            addr_q  <= cpu_addr;
            len_q   <= cpu_ar_len;
            size_q  <= cpu_size;
            resp_q  <= AXI_RESP_OKAY;
            state_q <= R_ADDR;
          end
        end
        R_ADDR: begin
          if (axi_ar_ready_i) begin
            state_q <= R_DATA;
          end
        end
        R_DATA: begin
          if (r_hs) begin
            beat_vld_q <= 1'b1;
            beat_dat_q <= axi_r_data_i;
            beat_idx_q <= cnt_q;
            cnt_q      <= cnt_d;
            resp_q     <= resp_d;
            if (axi_r_last_i) begin
              done_q  <= 1'b1;
              rdata_q <= aligned;
              state_q <= R_DONE;
            end
          end
        end
        R_DONE: state_q <= R_IDLE;
        default: state_q <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22041071_axi_r.sv
// Directed + randomized bench for the AXI read master with a byte-level reference model.
module tb_ysyx_22041071_axi_r;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cpu_ar_valid;
  logic        cpu_ar_ready;
  logic [3:0]  cpu_id;
  logic [31:0] cpu_addr;
  logic [7:0]  cpu_ar_len;
  logic [1:0]  cpu_size;
  logic        cpu_r_beat_valid;
  logic [63:0] cpu_r_beat_data;
  logic [7:0]  cpu_r_beat_idx;
  logic        cpu_r_done;
  logic [63:0] cpu_r_data;
  logic [1:0]  cpu_r_resp;
  logic        axi_ar_valid_o;
  logic        axi_ar_ready_i;
  logic [3:0]  axi_ar_id_o;
  logic [31:0] axi_ar_addr_o;
  logic [7:0]  axi_ar_len_o;
  logic [2:0]  axi_ar_size_o;
  logic [1:0]  axi_ar_burst_o;
  logic [2:0]  axi_ar_prot_o;
  logic [3:0]  axi_ar_cache_o;
  logic [3:0]  axi_ar_qos_o;
  logic [3:0]  axi_ar_region_o;
  logic        axi_ar_lock_o;
  logic        axi_ar_user_o;
  logic        axi_r_valid_i;
  logic        axi_r_ready_o;
  logic [3:0]  axi_r_id_i;
  logic [63:0] axi_r_data_i;
  logic [1:0]  axi_r_resp_i;
  logic        axi_r_last_i;
  logic        axi_r_user_i;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ysyx_22041071_axi_r dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_ar_valid(cpu_ar_valid), .cpu_ar_ready(cpu_ar_ready), .cpu_id(cpu_id),
    .cpu_addr(cpu_addr), .cpu_ar_len(cpu_ar_len), .cpu_size(cpu_size),
    .cpu_r_beat_valid(cpu_r_beat_valid), .cpu_r_beat_data(cpu_r_beat_data),
    .cpu_r_beat_idx(cpu_r_beat_idx), .cpu_r_done(cpu_r_done), .cpu_r_data(cpu_r_data),
    .cpu_r_resp(cpu_r_resp),
    .axi_ar_valid_o(axi_ar_valid_o), .axi_ar_ready_i(axi_ar_ready_i), .axi_ar_id_o(axi_ar_id_o),
    .axi_ar_addr_o(axi_ar_addr_o), .axi_ar_len_o(axi_ar_len_o), .axi_ar_size_o(axi_ar_size_o),
    .axi_ar_burst_o(axi_ar_burst_o), .axi_ar_prot_o(axi_ar_prot_o), .axi_ar_cache_o(axi_ar_cache_o),
    .axi_ar_qos_o(axi_ar_qos_o), .axi_ar_region_o(axi_ar_region_o), .axi_ar_lock_o(axi_ar_lock_o),
    .axi_ar_user_o(axi_ar_user_o),
    .axi_r_valid_i(axi_r_valid_i), .axi_r_ready_o(axi_r_ready_o), .axi_r_id_i(axi_r_id_i),
    .axi_r_data_i(axi_r_data_i), .axi_r_resp_i(axi_r_resp_i), .axi_r_last_i(axi_r_last_i),
    .axi_r_user_i(axi_r_user_i)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference alignment: pick bytes addr[2:0] .. addr[2:0]+nbytes-1 of the beat.
  function automatic logic [63:0] align_model(input logic [63:0] d, input logic [2:0] off,
                                              input logic [1:0] size);
    logic [63:0] r;
    int o;
    int nbytes;
    r = '0;
    o = int'(off);
    nbytes = 1 << size;
    for (int i = 0; i < nbytes; i++) begin
      if (o + i < 8) r[i*8 +: 8] = d[(o+i)*8 +: 8];
    end
    return r;
  endfunction

  // One complete read. The slave sends nbeats beats (RLAST on the final one).
  // gap_mode: 0 = back-to-back, 1 = every other cycle, 2 = random.
  task automatic run_txn(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] size, input int ar_wait, input int gap_mode,
                         input int nbeats, input int err_beat, input bit rnd_resp,
                         input logic [3:0] rid, input bit use_fixed, input logic [63:0] fixed,
                         output logic [63:0] got_data, output logic [1:0] got_resp);
    int sent;
    bit drive;
    bit hs;
    bit finished;
    logic [63:0] d;
    logic [1:0] r;
    logic [1:0] exp_resp;
    int exp_idx;
    sent = 0;
    finished = 0;
    exp_resp = 2'b00;
    got_data = '0;
    got_resp = '0;
    @(negedge clk);
    chk("cpu_ar_ready_idle", cpu_ar_ready, 1);
    cpu_ar_valid = 1'b1; cpu_id = id; cpu_addr = addr; cpu_ar_len = len; cpu_size = size;
    @(negedge clk);
    cpu_ar_valid = 1'b0; cpu_id = 4'($urandom); cpu_addr = $urandom;
    cpu_ar_len = 8'($urandom); cpu_size = 2'($urandom);
    chk("ar_valid", axi_ar_valid_o, 1);
    chk("ar_addr", axi_ar_addr_o, {addr[31:3], 3'b000});
    chk("ar_len", axi_ar_len_o, len);
    chk("ar_id", axi_ar_id_o, id);
    chk("ar_size", axi_ar_size_o, 3'b011);
    chk("ar_burst", axi_ar_burst_o, 2'b01);
    chk("cpu_ar_ready_busy", cpu_ar_ready, 0);
    for (int w = 0; w < ar_wait; w++) begin
      axi_ar_ready_i = 1'b0;
      @(negedge clk);
      chk("ar_valid_hold", axi_ar_valid_o, 1);
      chk("ar_addr_hold", axi_ar_addr_o, {addr[31:3], 3'b000});
      chk("ar_len_hold", axi_ar_len_o, len);
      chk("r_ready_early", axi_r_ready_o, 0);
    end
    axi_ar_ready_i = 1'b1;
    @(negedge clk);
    axi_ar_ready_i = 1'b0;
    chk("ar_valid_after_hs", axi_ar_valid_o, 0);
    chk("r_ready_data", axi_r_ready_o, 1);
    for (int cyc = 0; cyc < 300 && !finished; cyc++) begin
      drive = (sent < nbeats) &&
              (gap_mode == 0 || (gap_mode == 1 && cyc % 2 == 1) ||
               (gap_mode == 2 && $urandom_range(0, 1) == 1));
      d = use_fixed ? fixed : {$urandom, $urandom};
      if (err_beat >= 0) r = (sent == err_beat) ? 2'b10 : 2'b00;
      else if (rnd_resp) r = 2'($urandom_range(0, 2));
      else r = 2'b00;
      axi_r_valid_i = drive;
      axi_r_data_i  = d;
      axi_r_resp_i  = r;
      axi_r_id_i    = rid;
      axi_r_last_i  = drive && (sent == nbeats - 1);
      axi_r_user_i  = 1'($urandom);
      hs = drive && (axi_r_ready_o === 1'b1);
      @(negedge clk);
      axi_r_valid_i = 1'b0;
      if (hs) begin
        exp_idx = (sent < int'(len)) ? sent : int'(len);
        if (int'(r) > int'(exp_resp)) exp_resp = r;
`ifdef YSYX_22041071_AXI_R_ID_CHECK_EN
        if (rid != id) exp_resp = 2'b10;
`endif
        if (sent == nbeats - 1 && sent != int'(len)) exp_resp = 2'b10;
        if (sent != nbeats - 1 && sent >= int'(len)) exp_resp = 2'b10;
        chk("beat_valid", cpu_r_beat_valid, 1);
        chk("beat_data", cpu_r_beat_data, d);
        chk("beat_idx", cpu_r_beat_idx, 8'(exp_idx));
        if (sent == nbeats - 1) begin
          chk("done_pulse", cpu_r_done, 1);
          chk("r_data", cpu_r_data, align_model(d, addr[2:0], size));
          chk("r_resp", cpu_r_resp, exp_resp);
          got_data = cpu_r_data;
          got_resp = cpu_r_resp;
          finished = 1;
        end else begin
          chk("done_early", cpu_r_done, 0);
        end
        sent++;
      end else begin
        chk("beat_idle", cpu_r_beat_valid, 0);
        chk("done_idle", cpu_r_done, 0);
      end
    end
    chk("r_phase_finished", finished, 1);
    @(negedge clk);
    chk("done_single", cpu_r_done, 0);
    chk("beat_after_done", cpu_r_beat_valid, 0);
    chk("cpu_ar_ready_back", cpu_ar_ready, 1);
  endtask

  initial begin
    logic [63:0] gd;
    logic [1:0]  gr;
    logic [7:0]  len;
    logic [1:0]  sz;
    logic [31:0] ad;
    int          nb;
    reset_n = 1'b0; cpu_ar_valid = 1'b0; cpu_id = '0; cpu_addr = '0; cpu_ar_len = '0;
    cpu_size = '0; axi_ar_ready_i = 1'b0; axi_r_valid_i = 1'b0; axi_r_id_i = '0;
    axi_r_data_i = '0; axi_r_resp_i = '0; axi_r_last_i = 1'b0; axi_r_user_i = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    chk("rst_ar_ready", cpu_ar_ready, 1);
    chk("rst_ar_valid", axi_ar_valid_o, 0);
    chk("rst_r_ready", axi_r_ready_o, 0);
    chk("rst_beat_valid", cpu_r_beat_valid, 0);
    chk("rst_done", cpu_r_done, 0);
    chk("rst_resp", cpu_r_resp, 0);
    chk("rst_rdata", cpu_r_data, 0);
    chk("rst_ar_addr", axi_ar_addr_o, 0);

    // 4B read at offset 4 of an 8B beat
    run_txn(4'd1, 32'h8000_0004, 8'd0, 2'b10, 0, 0, 1, -1, 0, 4'd1, 1,
            64'h1122_3344_5566_7788, gd, gr);
    chk("t1_rdata", gd, 64'h1122_3344);
    chk("t1_resp", gr, 2'b00);

    // 4-beat burst with RVALID every other cycle
    run_txn(4'd3, 32'h8000_0100, 8'd3, 2'b11, 0, 1, 4, -1, 0, 4'd3, 0, '0, gd, gr);
    chk("t2_resp", gr, 2'b00);

    // AR stalled for 5 cycles
    run_txn(4'd7, 32'h8000_0208, 8'd1, 2'b11, 5, 0, 2, -1, 0, 4'd7, 0, '0, gd, gr);

    // SLVERR on beat 2; early RLAST; missing RLAST
    run_txn(4'd4, 32'h8000_0300, 8'd3, 2'b11, 0, 0, 4, 2, 0, 4'd4, 0, '0, gd, gr);
    chk("t4_err_beat_resp", gr, 2'b10);
    run_txn(4'd4, 32'h8000_0400, 8'd3, 2'b11, 0, 0, 2, -1, 0, 4'd4, 0, '0, gd, gr);
    chk("t4_early_last_resp", gr, 2'b10);
    run_txn(4'd5, 32'h8000_0500, 8'd1, 2'b11, 0, 0, 4, -1, 0, 4'd5, 0, '0, gd, gr);
    chk("t4_late_last_resp", gr, 2'b10);

    // Reset in the middle of a burst
    @(negedge clk);
    cpu_ar_valid = 1'b1; cpu_id = 4'd6; cpu_addr = 32'h8000_0600; cpu_ar_len = 8'd3; cpu_size = 2'b11;
    @(negedge clk);
    cpu_ar_valid = 1'b0; axi_ar_ready_i = 1'b1;
    @(negedge clk);
    axi_ar_ready_i = 1'b0; axi_r_valid_i = 1'b1; axi_r_data_i = {$urandom, $urandom};
    axi_r_last_i = 1'b0; axi_r_resp_i = 2'b00; axi_r_id_i = 4'd6;
    @(negedge clk);
    chk("t5_beat0", cpu_r_beat_valid, 1);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1; axi_r_valid_i = 1'b0;
    chk("t5_ar_ready", cpu_ar_ready, 1);
    chk("t5_ar_valid", axi_ar_valid_o, 0);
    chk("t5_r_ready", axi_r_ready_o, 0);
    chk("t5_beat_valid", cpu_r_beat_valid, 0);
    chk("t5_done", cpu_r_done, 0);
    chk("t5_resp", cpu_r_resp, 0);
    chk("t5_beat_data", cpu_r_beat_data, 0);
    repeat (3) begin
      @(negedge clk);
      chk("t5_no_done", cpu_r_done, 0);
    end
    run_txn(4'd2, 32'h8000_0703, 8'd0, 2'b00, 0, 0, 1, -1, 0, 4'd2, 1,
            64'h1122_3344_5566_7788, gd, gr);
    chk("t5_byte3", gd, 64'h55);

    // RID mismatch on a single beat
    run_txn(4'd2, 32'h8000_0800, 8'd0, 2'b11, 0, 0, 1, -1, 0, 4'd5, 0, '0, gd, gr);
`ifdef YSYX_22041071_AXI_R_ID_CHECK_EN
    chk("t6_rid_resp", gr, 2'b10);
`else
    chk("t6_rid_resp", gr, 2'b00);
`endif

    // Randomized transactions
    for (int t = 0; t < 30; t++) begin
      len = 8'($urandom_range(0, 7));
      sz  = 2'($urandom_range(0, 3));
      ad  = 32'h8000_0000 | ($urandom & 32'h0000_fff8);
      ad[2:0] = 3'($urandom_range(0, 7)) & ~3'((1 << sz) - 1);
      nb  = int'(len) + 1;
      if ($urandom_range(0, 5) == 0) nb = ($urandom_range(0, 1) == 1) ? nb + 2 : ((nb > 1) ? nb - 1 : nb);
      run_txn(4'($urandom), ad, len, sz, $urandom_range(0, 3), 2, nb, -1, 1,
              ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'd0, 0, '0, gd, gr);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
